// File: rtl/spi_mnrch_arb.sv
// Two-port arbiter in front of a single SPI_mnrch: latches one-cycle requests, grants
// round-robin, runs one transfer at a time and guards each transfer with a watchdog.
module spi_mnrch_arb #(
    parameter int TO_BITS = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt0,
    input  logic [15:0] cmd0,
    output logic        done0,
    output logic [15:0] rd_data0,
    input  logic        wrt1,
    input  logic [15:0] cmd1,
    output logic        done1,
    output logic [15:0] rd_data1,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_rd_data,
    output logic        busy,
    output logic        err_to,
    output logic        err_ovr
);

    typedef enum logic [1:0] {IDLE, LAUNCH, XFER} state_t;

    state_t             state;
    logic [1:0]         pend;
    logic [15:0]        cmd_q [2];
    logic [15:0]        rd_q [2];
    logic [1:0]         done_q;
    logic               gnt;
    logic               last_gnt;
    logic [TO_BITS-1:0] wd;
    logic [TO_BITS-1:0] wd_nxt;
    logic               finish;
    logic               win;
    logic [1:0]         wrt_v;
    logic [15:0]        cmd_v [2];

    always_comb begin
        wrt_v    = {wrt1, wrt0};
        cmd_v[0] = cmd0;
        cmd_v[1] = cmd1;
        wd_nxt   = wd + 1'b1;
        // Timeout once the counter would reach all-ones: 2**TO_BITS-1 clocks spent in XFER.
        finish   = (state == XFER) && (spi_done || (&wd_nxt));
        win      = (pend == 2'b11) ? ~last_gnt : pend[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend     <= '0;
            cmd_q[0] <= '0;
            cmd_q[1] <= '0;
            rd_q[0]  <= '0;
            rd_q[1]  <= '0;
            done_q   <= '0;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            wd       <= '0;
            spi_wrt  <= 1'b0;
            spi_cmd  <= '0;
            err_to   <= 1'b0;
            err_ovr  <= 1'b0;
        end else begin
            done_q  <= '0;
            spi_wrt <= 1'b0;

            for (int p = 0; p < 2; p++) begin
                if (finish && (gnt == p[0])) pend[p] <= 1'b0;
                // NOTE: the later non-blocking assignment wins, so a request arriving on the
                // same edge its pend clears is accepted rather than flagged as an overrun.
                if (wrt_v[p]) begin
                    if (pend[p] && !(finish && (gnt == p[0]))) begin
                        err_ovr <= 1'b1;
                    end else begin
                        pend[p]  <= 1'b1;
                        cmd_q[p] <= cmd_v[p];
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (|pend) begin
                        gnt     <= win;
                        spi_cmd <= cmd_q[win];
                        spi_wrt <= 1'b1;
                        state   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wd    <= '0;
                    state <= XFER;
                end
                XFER: begin
                    if (finish) begin
                        rd_q[gnt]   <= spi_done ? spi_rd_data : 16'h0000;
                        done_q[gnt] <= 1'b1;
                        last_gnt    <= gnt;
                        state       <= IDLE;
                        if (!spi_done) err_to <= 1'b1;
                    end else begin
                        wd <= wd_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign done0    = done_q[0];
    assign done1    = done_q[1];
    assign rd_data0 = rd_q[0];
    assign rd_data1 = rd_q[1];
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_spi_mnrch_arb.sv
// Randomized bench for spi_mnrch_arb: a transaction-level model of the request/grant rules
// predicts every output each cycle, with an SPI responder that may answer late or never.
module tb_spi_mnrch_arb;

    localparam int TO_BITS = 4;
    localparam int TO_CLKS = (1 << TO_BITS) - 1;

    logic        clk, rst_n;
    logic        wrt0, wrt1, done0, done1;
    logic [15:0] cmd0, cmd1, rd_data0, rd_data1;
    logic        spi_wrt, spi_done, busy, err_to, err_ovr;
    logic [15:0] spi_cmd, spi_rd_data;

    spi_mnrch_arb #(.TO_BITS(TO_BITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .wrt0(wrt0), .cmd0(cmd0), .done0(done0), .rd_data0(rd_data0),
        .wrt1(wrt1), .cmd1(cmd1), .done1(done1), .rd_data1(rd_data1),
        .spi_wrt(spi_wrt), .spi_cmd(spi_cmd), .spi_done(spi_done), .spi_rd_data(spi_rd_data),
        .busy(busy), .err_to(err_to), .err_ovr(err_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: requests waiting, who owns the bus, and what each port should show.
    bit          m_idle;
    bit   [1:0]  m_pend;
    logic [15:0] m_cmd [2];
    bit          m_last, m_gnt, m_tmo, m_to, m_ovr, launched;
    logic [15:0] m_hold [2];
    logic [15:0] m_spi_cmd, rd_exp;
    int          done_at, sd_at, launch_cyc;
    bit   [1:0]  d_wrt;
    logic [15:0] d_cmd [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_idle = 1; m_pend = 0; m_last = 1; m_gnt = 0; m_tmo = 0; m_to = 0; m_ovr = 0;
        m_cmd[0] = 0; m_cmd[1] = 0; m_hold[0] = 0; m_hold[1] = 0; m_spi_cmd = 0;
        done_at = -1; sd_at = -1; launch_cyc = -10; d_wrt = 0; launched = 0;
    endtask

    task automatic drive(input bit w0, input logic [15:0] c0, input bit w1, input logic [15:0] c1);
        wrt0 = w0; cmd0 = c0; wrt1 = w1; cmd1 = c1;
        d_wrt = {w1, w0}; d_cmd[0] = c0; d_cmd[1] = c1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wrt"}, spi_wrt, 0);
        check({tag, "_cmd"}, spi_cmd, 0);
        check({tag, "_done"}, {done1, done0}, 0);
        check({tag, "_rd0"}, rd_data0, 0);
        check({tag, "_rd1"}, rd_data1, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_errs"}, {err_to, err_ovr}, 0);
    endtask

    // One clock: compare every output against the model, then drive the next inputs.
    task automatic step(input bit rand_in);
        bit exp_wrt, exp_done, win, w0, w1;
        @(negedge clk);
        cyc++;
        launched = 0;
        exp_wrt = m_idle && (m_pend != 0);
        check("spi_wrt", spi_wrt, exp_wrt);
        if (exp_wrt) begin
            win = (m_pend == 2'b11) ? !m_last : m_pend[1];
            m_gnt = win; m_spi_cmd = m_cmd[win]; m_idle = 0;
            launched = 1; launch_cyc = cyc;
            if ($urandom_range(4) == 0) begin
                m_tmo = 1; rd_exp = 16'h0000; sd_at = -1; done_at = cyc + TO_CLKS + 1;
            end else begin
                m_tmo = 0; rd_exp = 16'($urandom);
                sd_at = cyc + int'($urandom_range(1, TO_CLKS)); done_at = sd_at + 1;
            end
        end
        check("spi_cmd", spi_cmd, m_spi_cmd);
        exp_done = !m_idle && (cyc == done_at);
        check("done0", done0, exp_done && (m_gnt == 0));
        check("done1", done1, exp_done && (m_gnt == 1));
        if (exp_done) begin
            m_hold[m_gnt] = rd_exp;
            m_pend[m_gnt] = 0;
            m_last = m_gnt;
            m_idle = 1;
            if (m_tmo) m_to = 1;
            sd_at = -1;
        end
        check("rd_data0", rd_data0, m_hold[0]);
        check("rd_data1", rd_data1, m_hold[1]);
        check("busy", busy, !m_idle);
        check("err_to", err_to, m_to);
        for (int p = 0; p < 2; p++) begin
            if (d_wrt[p]) begin
                if (m_pend[p]) m_ovr = 1;
                else begin m_pend[p] = 1; m_cmd[p] = d_cmd[p]; end
            end
        end
        check("err_ovr", err_ovr, m_ovr);

        spi_rd_data = 16'($urandom);
        if (cyc == sd_at) begin
            spi_done = 1; spi_rd_data = rd_exp;
        end else begin
            // Stray done pulses while idle or launching must be ignored.
            spi_done = ((m_idle && m_pend == 0) || launched) && ($urandom_range(3) == 0);
        end
        w0 = rand_in && ($urandom_range(11) == 0);
        w1 = rand_in && ($urandom_range(11) == 0);
        drive(w0, 16'($urandom), w1, 16'($urandom));
    endtask

    initial begin
        rst_n = 0; spi_done = 0; spi_rd_data = 0;
        model_reset();
        drive(0, 0, 0, 0);
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        check_all_zero("reset_held");
        rst_n = 1;
        drive(1, 16'hA600, 1, 16'h5A5A);

        for (int i = 0; i < 10 && !launched; i++) step(0);
        check("tie_port0_first", spi_cmd, 16'hA600);
        for (int i = 0; i < 3000; i++) step(1);

        for (int i = 0; i < 400 && !(!m_idle && cyc > launch_cyc); i++) step(1);
        check("reach_xfer", !m_idle && cyc > launch_cyc, 1);
        #2 rst_n = 0;
        #1 check_all_zero("midxfer_reset");
        model_reset();
        spi_done = 0;
        drive(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        drive(1, 16'h1234, 0, 0);
        for (int i = 0; i < 10 && !launched; i++) step(0);
        check("post_reset_cmd", spi_cmd, 16'h1234);
        for (int i = 0; i < 3000; i++) step(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
